dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
// - Data-side memory slave directly downstream of the pipelined core's M stage; consumes ALUResultM/WriteDataM/MemWriteM/byteEnable, returns RD_data.
// - Byte-enabled word RAM plus a small MMIO window:
//   - TX byte FIFO drained by a valid/ready stream.
//   - Free-running 64-bit cycle counter.
// - Requires no stall/handshake toward the core; all core accesses complete in the cycle presented.
// PARAMETERS
// - DEPTH_WORDS  1024            RAM depth in 32-bit words; power of 2
// - FIFO_DEPTH   8               TX FIFO entries; power of 2, >=2
// - MMIO_BASE    32'h1000_0000   MMIO window base; window = 256 B, decoded on addr[31:8]
// PORTS
// - clk          in   1   clock
// - reset        in   1   synchronous, active-high reset
// - ALUResultM   in   32  byte address from M stage
// - WriteDataM   in   32  store data, already lane-aligned
// - MemWriteM    in   1   store strobe, sampled at posedge clk
// - byteEnable   in   4   store byte lanes (bit i -> data[8i+7:8i])
// - RD_data      out  32  read data, combinational from ALUResultM
// - tx_data      out  8   FIFO head byte
// - tx_valid     out  1   FIFO non-empty
// - tx_ready     in   1   consumer accepts head when tx_valid && tx_ready
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous and active-high. Reset clears FIFO pointers/count, overflow flag, cycle counter, CTRL, tx_valid=0; RAM contents not reset.
// - Decode: mmio_sel = (ALUResultM[31:8]==MMIO_BASE[31:8]); otherwise RAM.
// - RAM index = ALUResultM[log2(DEPTH_WORDS)+1:2]; upper bits ignored (aliasing wrap).
// - RAM write at posedge when MemWriteM && !mmio_sel; only lanes with byteEnable set are written.
// - RAM read is asynchronous (zero latency). Same-cycle read of a location being written returns the old word.
// - MMIO map (word offsets; offset bits [1:0] ignored):
//   - 0x00 TXDATA
//     - W: push WriteDataM[7:0] when byteEnable[0]; no push otherwise.
//     - R: 0.
//   - 0x04 STATUS
//     - R: {16'b0, count[7:0], 5'b0, ovf, empty, full}.
//     - W: writing 1 to bit2 clears ovf.
//   - 0x08 CYCLE_LO
//     - R: cnt[31:0].
//     - W (any byteEnable): cnt <= 0 next cycle; the write overrides the increment.
//   - 0x0C CYCLE_HI
//     - R: cnt[63:32], live with no snapshot.
//     - W: ignored.
//   - Other offsets: read 0, writes ignored.
// - Cycle counter: cnt increments by 1 every cycle out of reset; wraps 2^64-1 -> 0.
// - FIFO:
//   - pop = tx_valid && tx_ready.
//   - push accepted iff count<FIFO_DEPTH or pop in the same cycle.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - Push when full without pop: byte dropped, ovf <= 1 (sticky); overflow-set has priority over a same-cycle clear.
//   - Push into an empty FIFO: tx_valid rises the next cycle (no bypass).
//   - Simultaneous push+pop: count unchanged.
//   - tx_data/tx_valid are stable while tx_valid && !tx_ready.
//   - full = (count==FIFO_DEPTH); empty = (count==0).
// - Reset asserted mid-stream: FIFO contents discarded, tx_valid=0 the cycle after reset is sampled.
// CONFIGURATION
// - Macro DMEM_TX_IRQ_EN.
// - Defined:
//   - Adds output port tx_irq (1 bit).
//   - Adds CTRL at offset 0x10: bit0 = irq enable; R/W; reset 0.
//   - tx_irq is registered: tx_irq <= CTRL[0] && (empty || ovf). Reset value 0; one-cycle latency.
// - Undefined:
//   - No tx_irq port.
//   - Offset 0x10 reads 0; writes ignored.
// TESTING
// - RAM byte lanes: sw 0xAABBCCDD @0x40, then sb 0x11 @0x41 (be=0010) -> read @0x40 = 0xAABB11DD.
// - Aliasing: write @(DEPTH_WORDS*4+0x8) -> read @0x8 returns the same word; MMIO space untouched.
// - FIFO fill: tx_ready=0, push 9 bytes 0x01..0x09 (FIFO_DEPTH=8) -> STATUS=0x0000_0805 (count 8, ovf, full); drain yields 0x01..0x08 in order, then tx_valid=0.
// - Push+pop when full: full FIFO, tx_ready=1, same-cycle push of 0x55 -> accepted, ovf stays 0, count stays 8, 0x55 is the last byte out.
// - Counter: after reset release read CYCLE_LO on cycle N -> N; write CYCLE_LO -> next-cycle read 0, then 1, 2, ...; CYCLE_HI=0.
// - DMEM_TX_IRQ_EN build: CTRL=1 with FIFO empty -> tx_irq=1 the next cycle; push 1 byte -> tx_irq=0 the cycle after; reset -> tx_irq=0.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data memory slave for the M stage: byte-enabled word RAM plus an MMIO window
// holding a TX byte FIFO and a 64-bit cycle counter. Optional tx_irq via DMEM_TX_IRQ_EN.
module dmem_mmio #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic [3:0]  byteEnable,
    output logic [31:0] RD_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
`ifdef DMEM_TX_IRQ_EN
    ,
    output logic        tx_irq
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned FW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = FW + 1;

    typedef enum logic [5:0] {
        OFF_TXDATA = 6'd0,
        OFF_STATUS = 6'd1,
        OFF_CYCLO  = 6'd2,
        OFF_CYCHI  = 6'd3,
        OFF_CTRL   = 6'd4
    } mmioReg_e;

    logic          mmioSel;
    logic [5:0]    offset;
    logic [AW-1:0] ramIdx;
    logic          mmioWr;
    logic          unusedAddrLsb;

    assign mmioSel       = (ALUResultM[31:8] == MMIO_BASE[31:8]);
    assign offset        = ALUResultM[7:2];
    assign ramIdx        = ALUResultM[AW+1:2];
    assign mmioWr        = MemWriteM && mmioSel;
    assign unusedAddrLsb = ^ALUResultM[1:0];

    // ---------------- RAM ----------------
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (MemWriteM && !mmioSel) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byteEnable[i]) mem[ramIdx][8*i +: 8] <= WriteDataM[8*i +: 8];
            end
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [FW-1:0] rdPtr, wrPtr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          full, empty;
    logic          pushReq, pushOk, pop, ovfClr;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = tx_valid && tx_ready;
    assign pushReq = mmioWr && (offset == OFF_TXDATA) && byteEnable[0];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pushOk  = pushReq && (!full || pop);
    assign ovfClr  = mmioWr && (offset == OFF_STATUS) && byteEnable[0] && WriteDataM[2];

    assign tx_valid = !empty;
    assign tx_data  = fifoMem[rdPtr];

    always_ff @(posedge clk) begin
        if (pushOk) fifoMem[wrPtr] <= WriteDataM[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (pop)    rdPtr <= rdPtr + 1'b1;
            case ({pushOk, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pushReq && !pushOk) ovf <= 1'b1;
            else if (ovfClr)        ovf <= 1'b0;
        end
    end

    // ---------------- Cycle counter ----------------
    logic [63:0] cnt;
    logic        cycWr;

    assign cycWr = mmioWr && (offset == OFF_CYCLO);

    always_ff @(posedge clk) begin
        if (reset)      cnt <= '0;
        else if (cycWr) cnt <= '0;
        else            cnt <= cnt + 64'd1;
    end

    // ---------------- Optional IRQ ----------------
`ifdef DMEM_TX_IRQ_EN
    logic ctrlEn;
    logic ctrlWr;

    assign ctrlWr = mmioWr && (offset == OFF_CTRL) && byteEnable[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrlEn <= 1'b0;
            tx_irq <= 1'b0;
        end else begin
            if (ctrlWr) ctrlEn <= WriteDataM[0];
            tx_irq <= ctrlEn && (empty || ovf);
        end
    end
`endif

    // ---------------- Read mux ----------------
    always_comb begin
        RD_data = '0;
        if (!mmioSel) begin
            RD_data = mem[ramIdx];
        end else begin
            case (offset)
                OFF_STATUS: RD_data = {16'b0, 8'(count), 5'b0, ovf, empty, full};
                OFF_CYCLO:  RD_data = cnt[31:0];
                OFF_CYCHI:  RD_data = cnt[63:32];
`ifdef DMEM_TX_IRQ_EN
                OFF_CTRL:   RD_data = {31'b0, ctrlEn};
`endif
                default:    RD_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus queues expected reads and TX bytes,
// a negedge monitor pops and compares. Covers DMEM_TX_IRQ_EN when defined.
module tb_dmem_mmio;

    localparam logic [31:0] MB      = 32'h1000_0000;
    localparam logic [31:0] A_TX    = MB + 32'h00;
    localparam logic [31:0] A_ST    = MB + 32'h04;
    localparam logic [31:0] A_CLO   = MB + 32'h08;
    localparam logic [31:0] A_CHI   = MB + 32'h0C;
    localparam logic [31:0] A_CTRL  = MB + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM, WriteDataM;
    logic        MemWriteM;
    logic [3:0]  byteEnable;
    logic [31:0] RD_data;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
`ifdef DMEM_TX_IRQ_EN
    logic        tx_irq;
`endif

    dmem_mmio #(.DEPTH_WORDS(1024), .FIFO_DEPTH(8), .MMIO_BASE(MB)) dut (
        .clk(clk), .reset(reset), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .MemWriteM(MemWriteM), .byteEnable(byteEnable), .RD_data(RD_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef DMEM_TX_IRQ_EN
        , .tx_irq(tx_irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 RD_data, 1 tx_valid, 2 tx_irq
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        rdQ[$];
    logic [7:0]  txQ[$];
    logic        rdChk = 1'b0;
    logic        curRdy = 1'b0;
    int          checks = 0;
    int          passes = 0;

    task automatic step(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                        input logic we, input logic rdy, input int kind,
                        input logic [31:0] exp, input string name);
        chk_t c;
        @(posedge clk); #1;
        ALUResultM = addr; WriteDataM = data; byteEnable = be; MemWriteM = we; tx_ready = rdy;
        if (kind >= 0) begin
            c.kind = kind; c.exp = exp; c.name = name;
            rdQ.push_back(c);
            rdChk = 1'b1;
        end else begin
            rdChk = 1'b0;
        end
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        step(addr, data, be, 1'b1, curRdy, -1, 32'h0, "");
    endtask

    task automatic ld(input logic [31:0] addr, input logic [31:0] exp, input string name);
        step(addr, 32'h0, 4'h0, 1'b0, curRdy, 0, exp, name);
    endtask

    task automatic chkSig(input int kind, input logic exp, input string name);
        step(32'h0, 32'h0, 4'h0, 1'b0, curRdy, kind, {31'b0, exp}, name);
    endtask

    task automatic nop();
        step(32'h0, 32'h0, 4'h0, 1'b0, curRdy, -1, 32'h0, "");
    endtask

    task automatic pulseReset();
        @(posedge clk); #1;
        reset = 1'b1; MemWriteM = 1'b0; rdChk = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents this cycle against the queues.
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        logic [7:0]  eb;
        if (rdChk) begin
            checks++;
            if (rdQ.size() == 0) begin
                $display("FAIL rd_underflow: no expected value queued");
            end else begin
                c = rdQ.pop_front();
                act = '0;
                case (c.kind)
                    0: act = RD_data;
                    1: act = {31'b0, tx_valid};
`ifdef DMEM_TX_IRQ_EN
                    2: act = {31'b0, tx_irq};
`endif
                    default: act = 32'hDEAD_BEEF;
                endcase
                if (act === c.exp) passes++;
                else $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
            end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            checks++;
            if (txQ.size() == 0) begin
                $display("FAIL tx_unexpected: got 0x%02h expected no byte", tx_data);
            end else begin
                eb = txQ.pop_front();
                if (tx_data === eb) passes++;
                else $display("FAIL tx_byte: got 0x%02h expected 0x%02h", tx_data, eb);
            end
        end
    end

    initial begin
        reset = 1'b1; ALUResultM = '0; WriteDataM = '0; MemWriteM = 1'b0;
        byteEnable = '0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and counter start
        ld(A_CLO, 32'd1, "cyc_first");
        ld(A_CHI, 32'd0, "cyc_hi");
        ld(A_ST, 32'h2, "status_reset");
        chkSig(1, 1'b0, "valid_reset");
        ld(A_CLO, 32'd5, "cyc_run");
        st(A_CLO, 32'hFFFF_FFFF, 4'hF);
        ld(A_CLO, 32'd0, "cyc_clr0");
        ld(A_CLO, 32'd1, "cyc_clr1");
        ld(A_CLO, 32'd2, "cyc_clr2");

        // RAM byte lanes, read-during-write, aliasing
        st(32'h40, 32'hAABB_CCDD, 4'hF);
        step(32'h41, 32'h0000_1100, 4'b0010, 1'b1, curRdy, 0, 32'hAABB_CCDD, "ram_old_on_wr");
        ld(32'h40, 32'hAABB_11DD, "ram_lane");
        st(32'h0000_1008, 32'h1234_5678, 4'hF);
        ld(32'h8, 32'h1234_5678, "ram_alias");
        ld(A_ST, 32'h2, "alias_mmio_untouched");
        ld(MB + 32'h20, 32'h0, "mmio_other");
`ifndef DMEM_TX_IRQ_EN
        ld(A_CTRL, 32'h0, "ctrl_absent");
`endif

        // FIFO: no push without lane 0, fill with overflow, drain in order
        st(A_TX, 32'hEE, 4'b0000);
        ld(A_ST, 32'h2, "no_push_be0");
        for (int i = 1; i <= 9; i++) begin
            st(A_TX, 32'(i), 4'b0001);
            if (i <= 8) txQ.push_back(8'(i));
        end
        ld(A_ST, 32'h0000_0805, "status_full_ovf");
        chkSig(1, 1'b1, "valid_full");
        curRdy = 1'b1;
        repeat (9) nop();
        chkSig(1, 1'b0, "valid_drained");
        ld(A_ST, 32'h6, "status_ovf_sticky");
        curRdy = 1'b0;
        st(A_ST, 32'h4, 4'b0001);
        ld(A_ST, 32'h2, "status_ovf_clr");

        // Push+pop on a full FIFO
        for (int i = 0; i < 8; i++) begin
            st(A_TX, 32'(8'h21 + i), 4'b0001);
            txQ.push_back(8'(8'h21 + i));
        end
        ld(A_ST, 32'h0000_0801, "status_full");
        step(A_TX, 32'h55, 4'b0001, 1'b1, 1'b1, -1, 32'h0, "");
        txQ.push_back(8'h55);
        ld(A_ST, 32'h0000_0801, "status_pushpop");
        curRdy = 1'b1;
        repeat (10) nop();
        chkSig(1, 1'b0, "valid_drained2");
        curRdy = 1'b0;

        // Reset mid-stream
        st(A_TX, 32'h77, 4'b0001);
        st(A_TX, 32'h78, 4'b0001);
        chkSig(1, 1'b1, "valid_prereset");
        pulseReset();
        chkSig(1, 1'b0, "valid_after_reset");
        ld(A_CLO, 32'd2, "cyc_after_reset");
        ld(A_ST, 32'h2, "status_after_reset");

`ifdef DMEM_TX_IRQ_EN
        chkSig(2, 1'b0, "irq_reset");
        st(A_CTRL, 32'h1, 4'b0001);
        chkSig(2, 1'b0, "irq_latency");
        chkSig(2, 1'b1, "irq_set");
        ld(A_CTRL, 32'h1, "ctrl_rd");
        st(A_TX, 32'h99, 4'b0001);
        chkSig(2, 1'b1, "irq_push_lag");
        chkSig(2, 1'b0, "irq_clr");
        pulseReset();
        chkSig(2, 1'b0, "irq_after_reset");
`endif

        nop();
        nop();
        checks++;
        if (txQ.size() == 0) passes++;
        else $display("FAIL tx_leftover: got %0d pending expected 0", txQ.size());
        checks++;
        if (rdQ.size() == 0) passes++;
        else $display("FAIL rd_leftover: got %0d pending expected 0", rdQ.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
